i2c_mst_ctrl_byte: RTL and testbench

//  Byte-level I2C master sequencer; sits directly upstream of the bit controller and drives its
//  cmd/din inputs while consuming its cmd_ack/dout/al outputs. Turns one host request (optional

---
 rtl/i2c_mst_ctrl_byte.sv | 170 +++++++++++++++++
 tb/tb_i2c_mst_ctrl_byte.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mst_ctrl_byte.sv
// Byte-level I2C master sequencer: expands one host request into START / data / ACK / STOP
// bit commands for the downstream bit controller, MSB first, with clean abort on arbitration loss.
module i2c_mst_ctrl_byte #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stop,
   input  logic            read,
   input  logic            write,
   input  logic            ack_in,
   input  logic [BITS-1:0] din,
   output logic            cmd_ack,
   output logic            ack_out,
   output logic [BITS-1:0] dout,
   output logic            i2c_al,
   output logic [3:0]      core_cmd,
   output logic            core_txd,
   input  logic            core_ack,
   input  logic            core_rxd,
   input  logic            core_al
);

   // state    | meaning
   // ST_IDLE  | waiting for a host request, core_cmd = NOP
   // ST_START | START condition in flight
   // ST_WRITE | data bit being transmitted
   // ST_READ  | data bit being received
   // ST_ACK   | ACK bit: received after a write, driven after a read
   // ST_STOP  | STOP condition in flight

   localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

   localparam logic [3:0] CMD_NOP   = 4'b0000;
   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WRITE,
      ST_READ,
      ST_ACK,
      ST_STOP
   } state_t;

   state_t          state;
   logic [BITS-1:0] sreg;
   logic [CW-1:0]   cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         core_cmd <= CMD_NOP;
         core_txd <= 1'b0;
         sreg     <= '0;
         cnt      <= '0;
         cmd_ack  <= 1'b0;
         ack_out  <= 1'b0;
         dout     <= '0;
         i2c_al   <= 1'b0;
      end else begin
         cmd_ack <= 1'b0;
         i2c_al  <= 1'b0;
         if (core_al) begin
            state    <= ST_IDLE;
            core_cmd <= CMD_NOP;
            core_txd <= 1'b0;
            i2c_al   <= 1'b1;
            cmd_ack  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  // cmd_ack blocks a relaunch while the host still holds the finished request
                  if ((start | read | write | stop) & ~cmd_ack) begin
                     sreg <= din;
                     cnt  <= CW'(BITS - 1);
                     if (start) begin
                        state    <= ST_START;
                        core_cmd <= CMD_START;
                     end else if (read) begin
                        state    <= ST_READ;
                        core_cmd <= CMD_READ;
                     end else if (write) begin
                        state    <= ST_WRITE;
                        core_cmd <= CMD_WRITE;
                        core_txd <= din[BITS-1];
                     end else begin
                        state    <= ST_STOP;
                        core_cmd <= CMD_STOP;
                     end
                  end
               end
               ST_START: begin
                  if (core_ack) begin
                     if (read) begin
                        state    <= ST_READ;
                        core_cmd <= CMD_READ;
                     end else if (write) begin
                        state    <= ST_WRITE;
                        core_cmd <= CMD_WRITE;
                        core_txd <= sreg[BITS-1];
                     end else begin
                        state    <= ST_IDLE;
                        core_cmd <= CMD_NOP;
                        cmd_ack  <= 1'b1;
                     end
                  end
               end
               ST_WRITE: begin
                  if (core_ack) begin
                     sreg <= sreg << 1;
                     if (cnt != '0) begin
                        cnt      <= cnt - 1'b1;
                        core_txd <= sreg[BITS-2];
                     end else begin
                        state    <= ST_ACK;
                        core_cmd <= CMD_READ;
                        core_txd <= 1'b1;
                     end
                  end
               end
               ST_READ: begin
                  if (core_ack) begin
                     sreg <= {sreg[BITS-2:0], core_rxd};
                     if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                     end else begin
                        state    <= ST_ACK;
                        core_cmd <= CMD_WRITE;
                        core_txd <= ack_in;
                        dout     <= {sreg[BITS-2:0], core_rxd};
                     end
                  end
               end
               ST_ACK: begin
                  if (core_ack) begin
                     // a READ bit command in the ACK phase means the byte was a write
                     if (core_cmd == CMD_READ)
                        ack_out <= core_rxd;
                     if (stop) begin
                        state    <= ST_STOP;
                        core_cmd <= CMD_STOP;
                     end else begin
                        state    <= ST_IDLE;
                        core_cmd <= CMD_NOP;
                        cmd_ack  <= 1'b1;
                     end
                  end
               end
               ST_STOP: begin
                  if (core_ack) begin
                     state    <= ST_IDLE;
                     core_cmd <= CMD_NOP;
                     cmd_ack  <= 1'b1;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  core_cmd <= CMD_NOP;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Bench for i2c_mst_ctrl_byte: emulates the bit controller and checks every cycle against a
// transaction-level list of the bit commands each request must produce.
module tb_i2c_mst_ctrl_byte;
   localparam int BITS = 8;
   localparam logic [3:0] C_NOP = 4'b0000, C_START = 4'b0001, C_STOP = 4'b0010,
                          C_WRITE = 4'b0100, C_READ = 4'b1000;

   logic clk = 1'b0, rst = 1'b1;
   logic start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0, ack_in = 1'b0;
   logic [BITS-1:0] din = '0;
   logic cmd_ack, ack_out, i2c_al, core_txd;
   logic [BITS-1:0] dout;
   logic [3:0] core_cmd;
   logic core_ack = 1'b0, core_rxd = 1'b0, core_al = 1'b0;

   int checks = 0, errors = 0;
   logic [BITS-1:0] exp_dout = '0;
   logic exp_ack_out = 1'b0;
   logic [BITS-1:0] last_wbits = '0;

   i2c_mst_ctrl_byte #(.BITS(BITS)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .read(read), .write(write),
      .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout),
      .i2c_al(i2c_al), .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
      .core_rxd(core_rxd), .core_al(core_al)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle_chk(input string nm);
      chk({nm, "_cmd"}, 32'(core_cmd), 32'(C_NOP));
      chk({nm, "_cmd_ack"}, 32'(cmd_ack), 32'd0);
      chk({nm, "_al"}, 32'(i2c_al), 32'd0);
   endtask

   task automatic data_chk(input string nm);
      chk({nm, "_dout"}, 32'(dout), 32'(exp_dout));
      chk({nm, "_ack_out"}, 32'(ack_out), 32'(exp_ack_out));
   endtask

   task automatic drop_req();
      start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   // Caller is positioned 1 time unit after a rising edge.
   task automatic run_req(input bit st, input bit sp, input bit rd, input bit wr,
                          input logic [BITS-1:0] d, input bit ai, input logic [BITS-1:0] rx,
                          input bit rxa, input int al_at, input int rst_at, input bit hold);
      logic [3:0] qc[$];
      logic       qt[$];
      bit         qv[$];
      int         qr[$];   // role: 0 start, 1 data bit, 2 ack bit, 3 stop
      int k, wait_c, cyc, off, nrd;
      bit done, aborted;
      logic [BITS-1:0] asm_rd;
      k = -1; wait_c = 0; cyc = 0; nrd = 0; done = 0; aborted = 0; asm_rd = '0;
      off = st ? 1 : 0;

      if (st) begin qc.push_back(C_START); qt.push_back(1'b0); qv.push_back(0); qr.push_back(0); end
      if (rd || wr) begin
         for (int i = BITS - 1; i >= 0; i--) begin
            qc.push_back(rd ? C_READ : C_WRITE);
            qt.push_back(d[i]); qv.push_back(!rd); qr.push_back(1);
         end
         qc.push_back(rd ? C_WRITE : C_READ);
         qt.push_back(rd ? ai : 1'b1); qv.push_back(1); qr.push_back(2);
         if (sp) begin qc.push_back(C_STOP); qt.push_back(1'b0); qv.push_back(0); qr.push_back(3); end
      end else if (!st && sp) begin
         qc.push_back(C_STOP); qt.push_back(1'b0); qv.push_back(0); qr.push_back(3);
      end

      start = st; stop = sp; read = rd; write = wr; din = d; ack_in = ai;
      core_ack = 1'b0; core_al = 1'b0;
      while (!done && cyc < 400) begin
         @(posedge clk);
         if (k < 0) begin
            k = 0; wait_c = $urandom_range(2, 4);
         end else if (core_al) begin
            aborted = 1;
         end else if (core_ack) begin
            if (qr[k] == 1 && rd) begin
               asm_rd = {asm_rd[BITS-2:0], core_rxd};
               nrd++;
               if (nrd == BITS) exp_dout = asm_rd;
            end
            if (qr[k] == 2 && !rd) exp_ack_out = core_rxd;
            k++;
            wait_c = $urandom_range(2, 4);
         end
         #1;
         cyc++;
         core_ack = 1'b0; core_al = 1'b0;
         if (aborted) begin
            chk("abort_cmd", 32'(core_cmd), 32'(C_NOP));
            chk("abort_txd", 32'(core_txd), 32'd0);
            chk("abort_al", 32'(i2c_al), 32'd1);
            chk("abort_cmd_ack", 32'(cmd_ack), 32'd1);
            data_chk("abort");
            done = 1;
         end else if (k == qc.size()) begin
            chk("done_cmd_ack", 32'(cmd_ack), 32'd1);
            chk("done_cmd", 32'(core_cmd), 32'(C_NOP));
            chk("done_al", 32'(i2c_al), 32'd0);
            data_chk("done");
            done = 1;
         end else begin
            chk("bit_cmd", 32'(core_cmd), 32'(qc[k]));
            if (qv[k]) chk("bit_txd", 32'(core_txd), 32'(qt[k]));
            chk("busy_cmd_ack", 32'(cmd_ack), 32'd0);
            chk("busy_al", 32'(i2c_al), 32'd0);
            data_chk("busy");
            if (k == rst_at) begin
               #2 rst = 1'b1;
               #1;
               chk("rst_cmd", 32'(core_cmd), 32'(C_NOP));
               chk("rst_txd", 32'(core_txd), 32'd0);
               chk("rst_dout", 32'(dout), 32'd0);
               chk("rst_cmd_ack", 32'(cmd_ack), 32'd0);
               chk("rst_al", 32'(i2c_al), 32'd0);
               chk("rst_ack_out", 32'(ack_out), 32'd0);
               exp_dout = '0; exp_ack_out = 1'b0;
               drop_req();
               @(posedge clk); #1 rst = 1'b0;
               @(posedge clk); #1;
               idle_chk("post_rst");
               return;
            end
            if (wait_c > 1) begin
               wait_c--;
               core_rxd = 1'($urandom_range(0, 1));
            end else begin
               core_ack = 1'b1;
               if (qr[k] == 1 && rd)       core_rxd = rx[BITS - 1 - (k - off)];
               else if (qr[k] == 2 && !rd) core_rxd = rxa;
               else                        core_rxd = 1'($urandom_range(0, 1));
               if (qr[k] == 1 && !rd) last_wbits = {last_wbits[BITS-2:0], core_txd};
               if (k == al_at) core_al = 1'b1;
            end
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout request never completed k=%0d required=%0d", k, qc.size());
      end
      if (!hold) drop_req();
      @(posedge clk); #1;
      idle_chk("after");
      if (hold) begin
         drop_req();
         @(posedge clk); #1;
         idle_chk("no_relaunch");
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cmd", 32'(core_cmd), 32'(C_NOP));
      chk("reset_txd", 32'(core_txd), 32'd0);
      chk("reset_cmd_ack", 32'(cmd_ack), 32'd0);
      chk("reset_ack_out", 32'(ack_out), 32'd0);
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_al", 32'(i2c_al), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      idle_chk("idle0");

      // start + write 0xA5 + stop, slave ACKs
      last_wbits = '0;
      run_req(1, 1, 0, 1, 8'hA5, 0, 8'h00, 0, -1, -1, 0);
      chk("t1_wbits", 32'(last_wbits), 32'h0A5);
      chk("t1_ack_out", 32'(ack_out), 32'd0);

      // read, master NACKs, stream 0,0,1,1,1,1,0,0
      run_req(0, 0, 1, 0, 8'h00, 1, 8'h3C, 0, -1, -1, 0);
      chk("t2_dout", 32'(dout), 32'h03C);

      // write 0xFF NACKed, then write ACKed
      last_wbits = '0;
      run_req(0, 0, 0, 1, 8'hFF, 0, 8'h00, 1, -1, -1, 0);
      chk("t3_wbits", 32'(last_wbits), 32'h0FF);
      chk("t3_ack_out_nack", 32'(ack_out), 32'd1);
      run_req(0, 0, 0, 1, 8'h12, 0, 8'h00, 0, -1, -1, 0);
      chk("t3_ack_out_ack", 32'(ack_out), 32'd0);

      // arbitration lost during the 4th write bit, then a normal write
      run_req(0, 0, 0, 1, 8'h96, 0, 8'h00, 1, 3, -1, 0);
      chk("t4_ack_out_held", 32'(ack_out), 32'd0);
      run_req(0, 1, 0, 1, 8'h69, 0, 8'h00, 1, -1, -1, 0);

      // request held through the cmd_ack cycle, then a fresh din
      run_req(0, 0, 0, 1, 8'h5A, 0, 8'h00, 0, -1, -1, 1);
      last_wbits = '0;
      run_req(0, 0, 0, 1, 8'hC3, 0, 8'h00, 0, -1, -1, 0);
      chk("t5_wbits", 32'(last_wbits), 32'h0C3);

      // reset during the 5th read bit
      run_req(0, 0, 1, 0, 8'h00, 0, 8'hE7, 0, -1, 4, 0);

      for (int i = 0; i < 40; i++) begin
         bit rd_r;
         int al;
         rd_r = 1'($urandom_range(0, 1));
         al = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 10)) : -1;
         run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd_r, !rd_r,
                 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), al, -1, ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
